// File: rtl/l2_request_arbiter_pkg.sv
// Shared definitions for the L2 request arbiter: packet layout, core-index width
// and the default number of requesting cores.
package l2_request_arbiter_pkg;

    localparam int NUM_CORES_DEFAULT = 4;
    localparam int CORE_W            = 4;
    localparam int ADDR_W            = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              valid;
        logic [CORE_W-1:0] core;
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
    } l2req_packet_t;

    // Increment a core index, wrapping back to zero after n-1.
    function automatic logic [CORE_W-1:0] wrap_inc(input logic [CORE_W-1:0] v, input int n);
        return (int'(v) >= n - 1) ? '0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/l2_request_arbiter_rr_pick.sv
// Round-robin find-first: returns the first eligible requester at or after the
// pointer, wrapping modulo N, ignoring any requester in the exclude mask.
module rr_pick
    import l2_request_arbiter_pkg::*;
#(
    parameter int N = NUM_CORES_DEFAULT
) (
    input  logic [N-1:0]      i_req,
    input  logic [CORE_W-1:0] i_ptr,
    input  logic [N-1:0]      i_excl,
    output logic [CORE_W-1:0] o_idx,
    output logic              o_found
);

    localparam int DW = CORE_W + 1;

    logic [N-1:0]  w_elig;
    logic [DW-1:0] w_dist [N];
    logic [DW-1:0] w_best;

    assign w_elig = i_req & ~i_excl;

    // Distance of each index from the pointer, walking forward with wrap.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dist
            assign w_dist[gi] = (DW'(gi) >= {1'b0, i_ptr})
                              ? DW'(gi) - {1'b0, i_ptr}
                              : DW'(gi + N) - {1'b0, i_ptr};
        end
    endgenerate

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_best  = '1;
        for (int i = 0; i < N; i++) begin
            if (w_elig[i] && (w_dist[i] < w_best)) begin
                w_best  = w_dist[i];
                o_idx   = CORE_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter forwarding one core request packet at a time to the L2.
// Packets are not buffered: the granted core's packet is passed straight through.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  l2req_packet_t        core_req [NUM_CORES],
    output logic [NUM_CORES-1:0] core_ready,
    output l2req_packet_t        l2req_packet,
    input  logic                 l2req_ready,
    output logic                 pc_event_l2_arb_wait
);

    arb_state_t           r_state, w_state_next;
    logic [CORE_W-1:0]    r_grant, w_grant_next;
    logic [CORE_W-1:0]    r_rr_ptr, w_rr_ptr_next;
    logic [NUM_CORES-1:0] w_valid;
    logic [NUM_CORES-1:0] w_excl;
    logic [CORE_W-1:0]    w_ptr_after;
    logic [CORE_W-1:0]    w_pick_ptr;
    logic [CORE_W-1:0]    w_pick_idx;
    logic                 w_pick_found;
    logic                 w_xfer;
    l2req_packet_t        w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign w_valid[gi]    = core_req[gi].valid;
            assign w_excl[gi]     = (r_state == ST_GRANTED) && (r_grant == CORE_W'(gi));
            assign core_ready[gi] = (r_state == ST_GRANTED) && (r_grant == CORE_W'(gi))
                                  && l2req_ready && core_req[gi].valid;
        end
    endgenerate

    always_comb begin
        w_sel = core_req[0];
        for (int i = 1; i < NUM_CORES; i++) begin
            if (r_grant == CORE_W'(i)) begin
                w_sel = core_req[i];
            end
        end
    end

    assign w_xfer      = |core_ready;
    assign w_ptr_after = wrap_inc(r_grant, NUM_CORES);
    // While granted, search for the follow-on grant as if the transfer happened.
    assign w_pick_ptr  = (r_state == ST_GRANTED) ? w_ptr_after : r_rr_ptr;

    rr_pick #(
        .N(NUM_CORES)
    ) u_rr_pick (
        .i_req   (w_valid),
        .i_ptr   (w_pick_ptr),
        .i_excl  (w_excl),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_rr_ptr_next = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_next = ST_GRANTED;
                    w_grant_next = w_pick_idx;
                end
            end
            ST_GRANTED: begin
                if (w_xfer) begin
                    w_rr_ptr_next = w_ptr_after;
                    if (w_pick_found) begin
                        w_grant_next = w_pick_idx;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (!w_sel.valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        l2req_packet       = w_sel;
        l2req_packet.core  = r_grant;
        l2req_packet.valid = (r_state == ST_GRANTED) && w_sel.valid;
    end

    assign pc_event_l2_arb_wait = |(w_valid & ~core_ready);

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Scoreboard bench: each scenario queues the expected transfer order, and the
// per-cycle monitor pops and compares whenever a core_ready strobe appears.
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset;
    l2req_packet_t core_req [NC];
    logic [NC-1:0] core_ready;
    l2req_packet_t l2req_packet;
    logic          l2req_ready;
    logic          pc_event_l2_arb_wait;

    l2_request_arbiter #(
        .NUM_CORES(NC)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .core_req             (core_req),
        .core_ready           (core_ready),
        .l2req_packet         (l2req_packet),
        .l2req_ready          (l2req_ready),
        .pc_event_l2_arb_wait (pc_event_l2_arb_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic [31:0] addr;
    } exp_t;

    exp_t          exp_q [$];
    int            xfer_cyc [$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            rem [NC];
    int            seq [NC];
    int            pulses [NC];
    logic [NC-1:0] consumed;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int c, input int s);
        return 32'(c * 256 + s);
    endfunction

    // Core field driven as all-ones so the arbiter's overwrite is visible.
    task automatic drive();
        for (int i = 0; i < NC; i++) begin
            core_req[i].valid = (rem[i] > 0);
            core_req[i].core  = 4'hF;
            core_req[i].op    = 2'(i);
            core_req[i].addr  = mk_addr(i, seq[i]);
        end
    endtask

    task automatic load(input int c, input int n);
        rem[c] = n;
        seq[c] = 0;
        drive();
    endtask

    task automatic expect_xfer(input int c, input int s);
        exp_t e;
        e.core = c;
        e.addr = mk_addr(c, s);
        exp_q.push_back(e);
        $display("push  core=%0d addr=%0h", c, e.addr);
    endtask

    task automatic mon();
        logic [NC-1:0] v;
        exp_t          e;
        consumed = core_ready;
        for (int i = 0; i < NC; i++) v[i] = core_req[i].valid;
        check("pc_event", 32'(pc_event_l2_arb_wait), 32'(|(v & ~core_ready)));
        check("ready_onehot", 32'($countones(core_ready) <= 1), 32'd1);
        if (core_ready != '0) begin
            for (int i = 0; i < NC; i++) if (core_ready[i]) pulses[i]++;
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'(core_ready), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("xfer  cycle=%0d core=%0d addr=%0h", cyc, l2req_packet.core, l2req_packet.addr);
                check("xfer_ready", 32'(core_ready), 32'(1) << e.core);
                check("xfer_core", 32'(l2req_packet.core), 32'(e.core));
                check("xfer_addr", l2req_packet.addr, e.addr);
                check("xfer_valid", 32'(l2req_packet.valid), 32'd1);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NC; i++) begin
            if (consumed[i]) begin
                rem[i] = rem[i] - 1;
                seq[i] = seq[i] + 1;
            end
        end
        drive();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        l2req_ready = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rem[i]    = 0;
            seq[i]    = 0;
            pulses[i] = 0;
        end
        drive();
        tick();
        tick();
        check("rst_ready", 32'(core_ready), 32'd0);
        check("rst_valid", 32'(l2req_packet.valid), 32'd0);
        check("rst_event", 32'(pc_event_l2_arb_wait), 32'd0);
        reset = 1'b0;
        xfer_cyc.delete();
    endtask

    task automatic drain(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        l2req_ready = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        drive();

        // Two sparse requesters: grant 0, then 2, then back to idle.
        do_reset();
        load(0, 1);
        load(2, 1);
        l2req_ready = 1'b1;
        expect_xfer(0, 0);
        expect_xfer(2, 0);
        settle();
        check("s1_idle_valid", 32'(l2req_packet.valid), 32'd0);
        tick();
        settle();
        check("s1_g0_core", 32'(l2req_packet.core), 32'd0);
        tick();
        settle();
        check("s1_g2_core", 32'(l2req_packet.core), 32'd2);
        tick();
        settle();
        check("s1_idle_end", 32'(l2req_packet.valid), 32'd0);
        drain("s1_drain");

        // All four cores streaming: strict rotation, one transfer per cycle.
        do_reset();
        for (int c = 0; c < NC; c++) load(c, 3);
        l2req_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < NC; c++) expect_xfer(c, k);
        repeat (16) tick();
        check("s2_count", 32'(xfer_cyc.size()), 32'd12);
        if (xfer_cyc.size() == 12)
            check("s2_span", 32'(xfer_cyc[11] - xfer_cyc[0]), 32'd11);
        drain("s2_drain");

        // Back-pressure: core 1 held for five cycles, then a single accept.
        do_reset();
        load(1, 1);
        expect_xfer(1, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            check("s3_hold_ready", 32'(core_ready), 32'd0);
            check("s3_hold_event", 32'(pc_event_l2_arb_wait), 32'd1);
            check("s3_hold_valid", 32'(l2req_packet.valid), 32'd1);
            check("s3_hold_addr", l2req_packet.addr, mk_addr(1, 0));
            tick();
        end
        l2req_ready = 1'b1;
        repeat (3) tick();
        settle();
        check("s3_pulses", 32'(pulses[1]), 32'd1);
        check("s3_ready_after", 32'(core_ready), 32'd0);
        drain("s3_drain");

        // Lone streamer on core 3: every other cycle, pointer wraps to 0.
        do_reset();
        load(3, 3);
        l2req_ready = 1'b1;
        for (int k = 0; k < 3; k++) expect_xfer(3, k);
        repeat (8) tick();
        check("s4_count", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3) begin
            check("s4_gap0", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd2);
            check("s4_gap1", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd2);
        end
        load(0, 1);
        load(3, 1);
        expect_xfer(0, 0);
        expect_xfer(3, 0);
        repeat (5) tick();
        drain("s4_drain");

        // Core 2 withdraws before acceptance: idle, no strobe, pointer kept.
        do_reset();
        load(2, 1);
        tick();
        settle();
        check("s5_granted", 32'(l2req_packet.core), 32'd2);
        check("s5_granted_v", 32'(l2req_packet.valid), 32'd1);
        rem[2] = 0;
        drive();
        tick();
        settle();
        check("s5_idle_valid", 32'(l2req_packet.valid), 32'd0);
        load(1, 1);
        load(3, 1);
        l2req_ready = 1'b1;
        expect_xfer(1, 0);
        expect_xfer(3, 0);
        repeat (5) tick();
        check("s5_no_pulse2", 32'(pulses[2]), 32'd0);
        drain("s5_drain");

        // Reset while granted: strobe suppressed, re-grant one cycle after release.
        do_reset();
        load(1, 1);
        tick();
        settle();
        check("s6_granted", 32'(l2req_packet.valid), 32'd1);
        reset       = 1'b1;
        l2req_ready = 1'b1;
        settle();
        check("s6_rst_ready", 32'(core_ready), 32'd0);
        check("s6_rst_valid", 32'(l2req_packet.valid), 32'd0);
        tick();
        reset = 1'b0;
        expect_xfer(1, 0);
        settle();
        check("s6_rel_idle", 32'(l2req_packet.valid), 32'd0);
        tick();
        settle();
        check("s6_regrant_v", 32'(l2req_packet.valid), 32'd1);
        check("s6_regrant_c", 32'(l2req_packet.core), 32'd1);
        repeat (2) tick();
        check("s6_pulses", 32'(pulses[1]), 32'd1);
        drain("s6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
